hf_spi_conf_rx: RTL

//  Parametrised SPI configuration receiver for the HF FPGA top level. Oversamples
//  the ARM's spck/ncs/mosi in the pck0 domain, decodes FRAME_W-bit command frames

---
 rtl/hf_spi_conf_rx_if.sv | 29 ++
 rtl/hf_spi_conf_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hf_spi_conf_rx_if.sv
// Bus bundle for the SPI configuration receiver: the ARM-side SPI pins,
// the mode_safe strobe, and the configuration/status outputs.
interface hf_spi_conf_rx_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int MODE_W   = 3
);
  logic                         spck;
  logic                         ncs;
  logic                         mosi;
  logic                         mode_safe;
  logic [NUM_REGS*DATA_W-1:0]   conf_regs;
  logic [MODE_W-1:0]            major_mode;
  logic                         mode_pend;
  logic                         mode_change;
  logic                         frame_err;
  logic                         cmd_err;
  logic [7:0]                   frame_cnt;

  modport slave (
    input  spck, ncs, mosi, mode_safe,
    output conf_regs, major_mode, mode_pend, mode_change, frame_err, cmd_err, frame_cnt
  );

  modport master (
    output spck, ncs, mosi, mode_safe,
    input  conf_regs, major_mode, mode_pend, mode_change, frame_err, cmd_err, frame_cnt
  );
endinterface

// File: rtl/hf_spi_conf_rx.sv
// SPI configuration receiver: oversamples spck/ncs/mosi in the pck0 domain,
// decodes command frames into config registers and commits major-mode
// changes only while mode_safe is high.

// Plain flop-chain synchroniser with a selectable reset level.
module hf_spi_conf_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain_q, chain_d;

  // Shift the raw input one stage deeper each cycle
  always_comb chain_d = {chain_q[STAGES-2:0], d};

  // Chain register; reset level chosen so the line looks idle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {STAGES{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];
endmodule

module hf_spi_conf_rx #(
  parameter int FRAME_W     = 16,
  parameter int CMD_W       = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int MODE_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pck0,
  input  logic             nreset,
  hf_spi_conf_rx_if.slave  bus
);
  localparam int               CNT_W     = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
  // Per-lane synchroniser reset levels {mosi, ncs, spck}: ncs idles high
  localparam logic [2:0]       SYNC_RST  = 3'b010;

  logic [2:0] raw_in, syn_in;
  logic       spck_s, ncs_s, mosi_s;

  assign raw_in = {bus.mosi, bus.ncs, bus.spck};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    hf_spi_conf_rx_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (SYNC_RST[i])
    ) u_sync (
      .clk   (pck0),
      .rst_n (nreset),
      .d     (raw_in[i]),
      .q     (syn_in[i])
    );
  end

  assign spck_s = syn_in[0];
  assign ncs_s  = syn_in[1];
  assign mosi_s = syn_in[2];

  // State
  logic                              spck_h_q, spck_h_d;
  logic                              ncs_h_q, ncs_h_d;
  logic [FRAME_W-1:0]                shift_q, shift_d;
  logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [MODE_W-1:0]                 pmode_q, pmode_d;
  logic                              pend_q, pend_d;
  logic [MODE_W-1:0]                 major_q, major_d;
  logic                              chg_q, chg_d;
  logic                              ferr_q, ferr_d;
  logic                              cerr_q, cerr_d;
  logic [7:0]                        fcnt_q, fcnt_d;

  logic                spck_rise, ncs_fall, ncs_rise;
  logic                reg0_wr;
  logic [CMD_W-1:0]    cmd;
  logic [DATA_W-1:0]   data;

  assign spck_rise = spck_s & ~spck_h_q;
  assign ncs_fall  = ~ncs_s & ncs_h_q;
  assign ncs_rise  = ncs_s & ~ncs_h_q;
  assign cmd       = shift_q[FRAME_W-1 -: CMD_W];
  assign data      = shift_q[DATA_W-1:0];

  // Edge history and bit capture; ncs falling edge starts a fresh count
  always_comb begin
    spck_h_d  = spck_s;
    ncs_h_d   = ncs_s;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (ncs_fall) bit_cnt_d = '0;
    if (!ncs_s && spck_rise) begin
      shift_d = {shift_q[FRAME_W-2:0], mosi_s};
      if (bit_cnt_d != CNT_MAX) bit_cnt_d = bit_cnt_d + 1'b1;
    end
  end

  // Frame decode on the synced ncs rising edge
  always_comb begin
    regs_d  = regs_q;
    ferr_d  = ferr_q;
    cerr_d  = cerr_q;
    fcnt_d  = fcnt_q;
    reg0_wr = 1'b0;
    if (ncs_rise) begin
      if (bit_cnt_q != CNT_FRAME) begin
        ferr_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
        if (&cmd) begin
          ferr_d = 1'b0;
          cerr_d = 1'b0;
        end else if (cmd != '0 && cmd <= CMD_W'(NUM_REGS)) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (cmd == CMD_W'(k + 1)) regs_d[k] = data;
          reg0_wr = (cmd == CMD_W'(1));
        end else begin
          cerr_d = 1'b1;
        end
      end
    end
  end

  // Mode commit: a commit consumes the old pending value, a same-cycle
  // reg0 write then re-arms pending with the new one
  always_comb begin
    pmode_d = pmode_q;
    pend_d  = pend_q;
    major_d = major_q;
    chg_d   = 1'b0;
    if (pend_q && bus.mode_safe) begin
      major_d = pmode_q;
      pend_d  = 1'b0;
      chg_d   = (pmode_q != major_q);
    end
    if (reg0_wr) begin
      pmode_d = data[DATA_W-1 -: MODE_W];
      pend_d  = 1'b1;
    end
  end

  // All state registers; reset leaves every mode "off" (all ones)
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      spck_h_q  <= 1'b0;
      ncs_h_q   <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      regs_q    <= '0;
      regs_q[0][DATA_W-1 -: MODE_W] <= '1;
      pmode_q   <= '1;
      pend_q    <= 1'b0;
      major_q   <= '1;
      chg_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cerr_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      spck_h_q  <= spck_h_d;
      ncs_h_q   <= ncs_h_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      regs_q    <= regs_d;
      pmode_q   <= pmode_d;
      pend_q    <= pend_d;
      major_q   <= major_d;
      chg_q     <= chg_d;
      ferr_q    <= ferr_d;
      cerr_q    <= cerr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.conf_regs   = regs_q;
  assign bus.major_mode  = major_q;
  assign bus.mode_pend   = pend_q;
  assign bus.mode_change = chg_q;
  assign bus.frame_err   = ferr_q;
  assign bus.cmd_err     = cerr_q;
  assign bus.frame_cnt   = fcnt_q;
endmodule
